// File: rtl/multicycle_ctrl.sv
// Control FSM for a multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects, counts retired instructions and traps on illegal/SYSTEM/timeout.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        alu_zero_i,
  input  logic        alu_lt_i,
  input  logic        alu_ltu_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_addr_sel_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic [1:0]  alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o,
  output logic        halted_o,
  output logic [1:0]  trap_cause_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Trap fires on the MEM_TIMEOUT-th consecutive wait cycle, i.e. when the count before it is one less.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;

  logic opcode_legal;
  logic branch_taken;
  logic is_store;
  logic wait_expired;

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode_i)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase

    branch_taken = 1'b0;
    case (funct3_i)
      3'b000:  branch_taken = alu_zero_i;
      3'b001:  branch_taken = ~alu_zero_i;
      3'b100:  branch_taken = alu_lt_i;
      3'b101:  branch_taken = ~alu_lt_i;
      3'b110:  branch_taken = alu_ltu_i;
      3'b111:  branch_taken = ~alu_ltu_i;
      default: branch_taken = 1'b0;
    endcase
  end

  assign is_store     = (opcode_i == OP_STORE);
  assign wait_expired = (wait_q == WAIT_LAST);

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_write_o     = 1'b0;
    pc_write_o     = 1'b0;
    pc_src_o       = 1'b0;
    alu_src_a_o    = 2'd0;
    alu_src_b_o    = 2'd0;
    alu_op_o       = 2'd0;
    reg_write_o    = 1'b0;
    wb_sel_o       = 2'd0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'd2;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (wait_expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      DECODE: begin
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd1;
        if (opcode_i == OP_SYSTEM) begin
          state_d = TRAP;
          cause_d = CAUSE_SYSTEM;
        end else if (!opcode_legal ||
                     (opcode_i == OP_BRANCH && funct3_i[2:1] == 2'b01)) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        case (opcode_i)
          OP_R: begin
            alu_src_a_o = 2'd2;
            alu_op_o    = 2'd2;
            state_d     = WB;
          end
          OP_I: begin
            alu_src_a_o = 2'd2;
            alu_src_b_o = 2'd1;
            alu_op_o    = 2'd2;
            state_d     = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a_o = 2'd2;
            alu_src_b_o = 2'd1;
            state_d     = MEM;
          end
          OP_BRANCH: begin
            alu_src_a_o = 2'd2;
            alu_op_o    = 2'd1;
            pc_write_o  = branch_taken;
            pc_src_o    = 1'b1;
          end
          OP_JAL: begin
            pc_write_o  = 1'b1;
            pc_src_o    = 1'b1;
            reg_write_o = 1'b1;
            wb_sel_o    = 2'd2;
          end
          OP_JALR: begin
            alu_src_a_o = 2'd2;
            alu_src_b_o = 2'd1;
            pc_write_o  = 1'b1;
            reg_write_o = 1'b1;
            wb_sel_o    = 2'd2;
          end
          OP_LUI: begin
            reg_write_o = 1'b1;
            wb_sel_o    = 2'd3;
          end
          OP_AUIPC: reg_write_o = 1'b1;
          default: begin
            // IR changed under us; treat as illegal rather than retire garbage.
            state_d = TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end

      MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = is_store;
        if (mem_ready_i) begin
          state_d = is_store ? FETCH : WB;
        end else if (wait_expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      WB: begin
        reg_write_o = 1'b1;
        wb_sel_o    = (opcode_i == OP_LOAD) ? 2'd1 : 2'd0;
        state_d     = FETCH;
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase

    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_req_o && !mem_ready_i) begin
      wait_d = wait_q + 8'd1;
    end

    instret_d = instret_q;
    if (state_d == FETCH && (state_q == EXEC || state_q == MEM || state_q == WB)) begin
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= 8'd0;
      cause_q   <= 2'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign state_o      = state_q;
  assign halted_o     = (state_q == TRAP);
  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built from the ISA-level
// sequencing rules, replayed against the DUT with random opcodes, flags and memory waits.
module tb_multicycle_ctrl;
  localparam int TMO = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       halted;
    logic [1:0] cause;
  } outs_t;

  typedef struct packed {
    logic [2:0] st;
    logic       rdy;
    outs_t      o;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, halted;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;
  outs_t       act;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_instret = 32'd0;
  ent_t        q[$];
  logic [6:0]  legal_ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                  OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .funct3_i(funct3),
    .alu_zero_i(alu_zero), .alu_lt_i(alu_lt), .alu_ltu_i(alu_ltu), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_sel_o(mem_addr_sel),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .reg_write_o(reg_write), .wb_sel_o(wb_sel), .state_o(state), .halted_o(halted),
    .trap_cause_o(trap_cause), .instret_o(instret)
  );

  assign act = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, wb_sel, halted, trap_cause};

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t mk(input logic [2:0] st);
    ent_t e;
    e = '0;
    e.st = st;
    e.rdy = 1'($urandom);   // mem_ready must not matter outside memory phases
    return e;
  endfunction

  function automatic ent_t mem_ent(input logic [2:0] st, input logic store);
    ent_t e;
    e = mk(st);
    e.o.mem_req = 1'b1;
    if (st == S_FETCH) e.o.src_b = 2'd2;
    else begin
      e.o.mem_addr_sel = 1'b1;
      e.o.mem_we = store;
    end
    return e;
  endfunction

  task automatic push_trap(input logic [1:0] c);
    ent_t e;
    for (int i = 0; i < 2; i++) begin
      e = mk(S_TRAP);
      e.o.halted = 1'b1;
      e.o.cause = c;
      q.push_back(e);
    end
  endtask

  // A memory phase lasts w wait cycles plus the completing cycle, unless w reaches the timeout.
  task automatic push_wait(input logic [2:0] st, input int w, input logic store, output bit tmo);
    ent_t e;
    int n;
    tmo = (w >= TMO);
    n = tmo ? TMO : w;
    for (int i = 0; i < n; i++) begin
      e = mem_ent(st, store);
      e.rdy = 1'b0;
      q.push_back(e);
    end
    if (!tmo) begin
      e = mem_ent(st, store);
      e.rdy = 1'b1;
      if (st == S_FETCH) begin
        e.o.ir_write = 1'b1;
        e.o.pc_write = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z,
                           input logic lt, input logic ltu, input int fw, input int mw,
                           input string name, output bit trapped);
    ent_t e;
    bit   tmo;
    logic tk;
    q.delete();
    trapped = 1'b0;
    push_wait(S_FETCH, fw, 1'b0, tmo);
    if (tmo) begin
      push_trap(2'd3);
      trapped = 1'b1;
    end else begin
      e = mk(S_DECODE);
      e.o.src_a = 2'd1;
      e.o.src_b = 2'd1;
      q.push_back(e);
      if (op == OP_SYSTEM) begin
        push_trap(2'd2);
        trapped = 1'b1;
      end else if (!is_legal(op) || (op == OP_BRANCH && (f3 == 3'b010 || f3 == 3'b011))) begin
        push_trap(2'd1);
        trapped = 1'b1;
      end else begin
        e = mk(S_EXEC);
        case (op)
          OP_R, OP_I: begin
            e.o.src_a = 2'd2;
            e.o.src_b = (op == OP_I) ? 2'd1 : 2'd0;
            e.o.alu_op = 2'd2;
            q.push_back(e);
            e = mk(S_WB);
            e.o.reg_write = 1'b1;
            q.push_back(e);
          end
          OP_LOAD, OP_STORE: begin
            e.o.src_a = 2'd2;
            e.o.src_b = 2'd1;
            q.push_back(e);
            push_wait(S_MEM, mw, (op == OP_STORE), tmo);
            if (tmo) begin
              push_trap(2'd3);
              trapped = 1'b1;
            end else if (op == OP_LOAD) begin
              e = mk(S_WB);
              e.o.reg_write = 1'b1;
              e.o.wb_sel = 2'd1;
              q.push_back(e);
            end
          end
          OP_BRANCH: begin
            tk = 1'b0;
            case (f3)
              3'b000: tk = z;
              3'b001: tk = !z;
              3'b100: tk = lt;
              3'b101: tk = !lt;
              3'b110: tk = ltu;
              3'b111: tk = !ltu;
              default: tk = 1'b0;
            endcase
            e.o.src_a = 2'd2;
            e.o.alu_op = 2'd1;
            e.o.pc_src = 1'b1;
            e.o.pc_write = tk;
            q.push_back(e);
          end
          OP_JAL: begin
            e.o.pc_write = 1'b1;
            e.o.pc_src = 1'b1;
            e.o.reg_write = 1'b1;
            e.o.wb_sel = 2'd2;
            q.push_back(e);
          end
          OP_JALR: begin
            e.o.src_a = 2'd2;
            e.o.src_b = 2'd1;
            e.o.pc_write = 1'b1;
            e.o.reg_write = 1'b1;
            e.o.wb_sel = 2'd2;
            q.push_back(e);
          end
          OP_LUI: begin
            e.o.reg_write = 1'b1;
            e.o.wb_sel = 2'd3;
            q.push_back(e);
          end
          default: begin
            e.o.reg_write = 1'b1;
            q.push_back(e);
          end
        endcase
      end
    end

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        opcode = op; funct3 = f3; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
      end
      mem_ready = q[i].rdy;
      #1;
      checks++;
      if (state !== q[i].st) begin
        failures++;
        $display("FAIL %s cyc%0d state: got %0d want %0d", name, i, state, q[i].st);
      end
      checks++;
      if (act !== q[i].o) begin
        failures++;
        $display("FAIL %s cyc%0d outputs: got %h want %h", name, i, act, q[i].o);
      end
      checks++;
      if (instret !== exp_instret) begin
        failures++;
        $display("FAIL %s cyc%0d instret: got %0d want %0d", name, i, instret, exp_instret);
      end
    end
    if (!trapped) exp_instret++;
    $display("txn %s op=%b f3=%b fw=%0d mw=%0d cycles=%0d trap=%0d instret=%0d",
             name, op, f3, fw, mw, q.size(), trapped, exp_instret);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    exp_instret = 32'd0;
    checks++;
    if (state !== S_IDLE || act !== outs_t'(0) || instret !== 32'd0) begin
      failures++;
      $display("FAIL reset_assert: got state=%0d outs=%h instret=%0d want 0/0/0", state, act, instret);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (state !== S_IDLE || act !== outs_t'(0)) begin
      failures++;
      $display("FAIL reset_release: got state=%0d outs=%h want 0/0", state, act);
    end
  endtask

  // Consumes one FETCH cycle, so callers follow it with a reset.
  task automatic peek_fetch(input string name);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== S_FETCH || instret !== exp_instret) begin
      failures++;
      $display("FAIL %s: got state=%0d instret=%0d want %0d/%0d", name, state, instret, S_FETCH, exp_instret);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_add();
    bit tr;
    do_reset();
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "add", tr);
    peek_fetch("add_end");
  endtask

  task automatic test_branch();
    bit tr;
    do_reset();
    run_instr(OP_BRANCH, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, "beq_taken", tr);
    run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1, 0, 0, "beq_not", tr);
    run_instr(OP_BRANCH, 3'b111, 1'b0, 1'b1, 1'b0, 0, 0, "bgeu_taken", tr);
    run_instr(OP_BRANCH, 3'b100, 1'b0, 1'b1, 1'b0, 1, 0, "blt_taken", tr);
    peek_fetch("branch_end");
  endtask

  task automatic test_load_wait();
    bit tr;
    do_reset();
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3, "load_wait3", tr);
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 2, 2, "store_wait", tr);
    run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "jalr", tr);
    peek_fetch("load_end");
  endtask

  task automatic test_timeout();
    bit tr;
    do_reset();
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, TMO, 0, "fetch_timeout", tr);
    do_reset();
    run_instr(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, TMO - 1, 0, "fetch_last_ready", tr);
    run_instr(OP_LOAD, 3'b000, 1'b0, 1'b0, 1'b0, TMO - 1, TMO, "mem_timeout", tr);
    do_reset();
    run_instr(OP_STORE, 3'b000, 1'b0, 1'b0, 1'b0, 0, TMO - 1, "mem_last_ready", tr);
    peek_fetch("timeout_end");
  endtask

  task automatic test_illegal();
    bit tr;
    do_reset();
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "pre_illegal", tr);
    run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "illegal_op", tr);
    do_reset();
    run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "lui", tr);
    run_instr(OP_SYSTEM, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "system", tr);
    do_reset();
    run_instr(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "auipc", tr);
    run_instr(OP_BRANCH, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0, "branch_f3_011", tr);
  endtask

  task automatic test_reset_abort();
    bit tr;
    do_reset();
    run_instr(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "pre_abort_add", tr);
    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, "pre_abort_jal", tr);
    @(negedge clk);
    opcode = OP_LOAD; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== S_MEM || mem_req !== 1'b1 || instret !== 32'd2) begin
      failures++;
      $display("FAIL abort_pre: got state=%0d mem_req=%b instret=%0d want 4/1/2", state, mem_req, instret);
    end
    rst_n = 1'b0;
    #1;
    exp_instret = 32'd0;
    checks++;
    if (state !== S_IDLE || mem_req !== 1'b0 || instret !== 32'd0) begin
      failures++;
      $display("FAIL abort_reset: got state=%0d mem_req=%b instret=%0d want 0/0/0", state, mem_req, instret);
    end
    @(negedge clk);
    rst_n = 1'b1;
    peek_fetch("abort_resume");
    $display("txn reset_abort done");
  endtask

  task automatic test_random();
    bit tr;
    logic [6:0] op;
    int r, fw, mw;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85) op = legal_ops[$urandom_range(0, 8)];
      else if (r < 90) op = OP_SYSTEM;
      else op = 7'($urandom);
      fw = ($urandom_range(0, 24) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 19) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), fw, mw, "rand", tr);
      if (tr) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_load_wait();
    test_timeout();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
